// File: rtl/acc_grp.sv
// acc_grp: stream reducer that sums each group of N accepted beats into one
// result beat; a beat carrying last closes the group early and ends the frame.
// Optional feature macro: ACC_GRP_SAT_EN (saturating adder instead of wrap).
// Flag packing: mflags = {again, first, last, vld}, sflags = {abt, bsy}.
module acc_grp #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] N,
    input  logic [W-1:0] uc_d0,
    input  logic [3:0]   uc_mflags,
    output logic [1:0]   cu_sflags,
    output logic [W-1:0] cd_d0,
    output logic [3:0]   cd_mflags,
    input  logic [1:0]   dc_sflags
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACC  = 1'b1;

    logic [0:0]   state, state_n;
    logic [W-1:0] acc, acc_n;
    logic [W-1:0] cnt, cnt_n;
    logic [W-1:0] nlat, nlat_n;
    logic         first_pend, first_pend_n;
    logic         full, full_n;
    logic [W-1:0] out_d, out_d_n;
    logic         out_first, out_first_n;
    logic         out_last, out_last_n;

    logic         uc_vld, uc_last, uc_first, uc_again;
    logic         dc_bsy, dc_abt;
    logic         cu_bsy_c, accept_c, take_c, grp_start_c, close_c;
    logic [W-1:0] base_c, sum_c, cnt_eff_c, cnt_inc_c, nlat_eff_c;
    logic         first_eff_c;

    assign uc_vld   = uc_mflags[0];
    assign uc_last  = uc_mflags[1];
    assign uc_first = uc_mflags[2];
    assign uc_again = uc_mflags[3];
    assign dc_bsy   = dc_sflags[0];
    assign dc_abt   = dc_sflags[1];

    // Output register is occupied and not draining: stall upstream
    assign cu_bsy_c  = full & dc_bsy;
    assign cu_sflags = {dc_abt, cu_bsy_c};
    assign cd_d0     = out_d;
    assign cd_mflags = {cu_bsy_c, out_first, out_last, full};

    // Beat qualification, group-start selection and close detection
    always_comb begin
        accept_c    = uc_vld & ~uc_again & ~cu_bsy_c;
        take_c      = accept_c & ((state == S_ACC) | uc_first);
        grp_start_c = uc_first | (cnt == '0);
        base_c      = grp_start_c ? '0 : acc;
        cnt_eff_c   = uc_first ? '0 : cnt;
        nlat_eff_c  = uc_first ? N : nlat;
        first_eff_c = uc_first | first_pend;
        cnt_inc_c   = cnt_eff_c + W'(1);
        close_c     = uc_last | ((nlat_eff_c != '0) && (cnt_inc_c == nlat_eff_c));
    end

    // Adder: saturating when the feature is enabled, modulo 2^W otherwise
`ifdef ACC_GRP_SAT_EN
    logic [W:0] sum_wide_c;
    always_comb begin
        sum_wide_c = {1'b0, base_c} + {1'b0, uc_d0};
        sum_c      = sum_wide_c[W] ? {W{1'b1}} : sum_wide_c[W-1:0];
    end
`else
    always_comb begin
        sum_c = base_c + uc_d0;
    end
`endif

    // Next-state and register-next computation; abort has priority over beats
    always_comb begin
        state_n      = state;
        acc_n        = acc;
        cnt_n        = cnt;
        nlat_n       = nlat;
        first_pend_n = first_pend;
        full_n       = full & dc_bsy;
        out_d_n      = out_d;
        out_first_n  = out_first;
        out_last_n   = out_last;
        if (dc_abt) begin
            state_n      = S_IDLE;
            full_n       = 1'b0;
            acc_n        = '0;
            cnt_n        = '0;
            first_pend_n = 1'b0;
        end else if (take_c) begin
            nlat_n = nlat_eff_c;
            if (close_c) begin
                out_d_n      = sum_c;
                out_first_n  = first_eff_c;
                out_last_n   = uc_last;
                full_n       = 1'b1;
                first_pend_n = 1'b0;
                cnt_n        = '0;
                state_n      = uc_last ? S_IDLE : S_ACC;
            end else begin
                acc_n        = sum_c;
                cnt_n        = cnt_inc_c;
                first_pend_n = first_eff_c;
                state_n      = S_ACC;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            nlat       <= '0;
            first_pend <= 1'b0;
            full       <= 1'b0;
            out_d      <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            cnt        <= cnt_n;
            nlat       <= nlat_n;
            first_pend <= first_pend_n;
            full       <= full_n;
            out_d      <= out_d_n;
            out_first  <= out_first_n;
            out_last   <= out_last_n;
        end
    end

endmodule

// File: tb/tb_acc_grp.sv
// Directed bench for acc_grp (W=32); expectations are hand-computed.
module tb_acc_grp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] N;
    logic [31:0] uc_d0;
    logic [3:0]  uc_mflags;
    logic [1:0]  cu_sflags;
    logic [31:0] cd_d0;
    logic [3:0]  cd_mflags;
    logic [1:0]  dc_sflags;

    int tests = 0;
    int fails = 0;

    acc_grp #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .N         (N),
        .uc_d0     (uc_d0),
        .uc_mflags (uc_mflags),
        .cu_sflags (cu_sflags),
        .cd_d0     (cd_d0),
        .cd_mflags (cd_mflags),
        .dc_sflags (dc_sflags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic f, input logic l);
        uc_d0     = d;
        uc_mflags = {1'b0, f, l, 1'b1};
    endtask

    task automatic idle();
        uc_d0     = '0;
        uc_mflags = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; N = '0; dc_sflags = 2'b00; idle();
        repeat (2) tick();
        tests++;
        if (cd_d0 !== 32'd0) begin fails++; $display("FAIL reset_d0 got %0h exp 0", cd_d0); end
        tests++;
        if (cd_mflags !== 4'b0000) begin fails++; $display("FAIL reset_mflags got %b exp 0000", cd_mflags); end
        tests++;
        if (cu_sflags !== 2'b00) begin fails++; $display("FAIL reset_sflags got %b exp 00", cu_sflags); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        N = 32'd3;
        for (int i = 1; i <= 6; i++) begin
            drive(32'(i), i == 1, i == 6);
            tick();
            if (i == 3) begin
                tests++;
                if (cd_d0 !== 32'd6 || cd_mflags !== 4'b0101) begin
                    fails++; $display("FAIL basic_g1 got %0d/%b exp 6/0101", cd_d0, cd_mflags);
                end
            end
            if (i == 4) begin
                tests++;
                if (cd_mflags[0] !== 1'b0) begin fails++; $display("FAIL basic_drain vld got %b exp 0", cd_mflags[0]); end
            end
            if (i == 6) begin
                tests++;
                if (cd_d0 !== 32'd15 || cd_mflags !== 4'b0011) begin
                    fails++; $display("FAIL basic_g2 got %0d/%b exp 15/0011", cd_d0, cd_mflags);
                end
            end
        end
        idle(); tick();
    endtask

    task automatic test_short();
        logic [31:0] v [5];
        v[0] = 10; v[1] = 20; v[2] = 30; v[3] = 40; v[4] = 5;
        N = 32'd4;
        for (int i = 0; i < 5; i++) begin
            drive(v[i], i == 0, i == 4);
            tick();
            if (i == 3) begin
                tests++;
                if (cd_d0 !== 32'd100 || cd_mflags !== 4'b0101) begin
                    fails++; $display("FAIL short_g1 got %0d/%b exp 100/0101", cd_d0, cd_mflags);
                end
            end
            if (i == 4) begin
                tests++;
                if (cd_d0 !== 32'd5 || cd_mflags !== 4'b0011) begin
                    fails++; $display("FAIL short_close got %0d/%b exp 5/0011", cd_d0, cd_mflags);
                end
            end
        end
        idle(); tick();
        N = 32'd0;
        for (int i = 0; i < 3; i++) begin
            drive(32'(7 + i), i == 0, i == 2);
            tick();
            if (i < 2) begin
                tests++;
                if (cd_mflags[0] !== 1'b0) begin fails++; $display("FAIL n0_noout_%0d vld got %b exp 0", i, cd_mflags[0]); end
            end
        end
        tests++;
        if (cd_d0 !== 32'd24 || cd_mflags !== 4'b0111) begin
            fails++; $display("FAIL n0_frame got %0d/%b exp 24/0111", cd_d0, cd_mflags);
        end
        idle(); tick();
    endtask

    task automatic test_backpressure();
        N = 32'd2;
        drive(32'd1, 1'b1, 1'b0); tick();
        drive(32'd2, 1'b0, 1'b0); tick();
        tests++;
        if (cd_d0 !== 32'd3 || cd_mflags !== 4'b0101) begin
            fails++; $display("FAIL bp_first got %0d/%b exp 3/0101", cd_d0, cd_mflags);
        end
        dc_sflags = 2'b01;
        drive(32'd3, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (cu_sflags !== 2'b01 || cd_d0 !== 32'd3 || cd_mflags !== 4'b1101) begin
                fails++; $display("FAIL bp_hold_%0d got bsy=%b d0=%0d fl=%b exp 01/3/1101", c, cu_sflags, cd_d0, cd_mflags);
            end
            tick();
        end
        dc_sflags = 2'b00;
        #1;
        tests++;
        if (cu_sflags !== 2'b00) begin fails++; $display("FAIL bp_release got %b exp 00", cu_sflags); end
        tick();
        tests++;
        if (cd_mflags[0] !== 1'b0) begin fails++; $display("FAIL bp_drained vld got %b exp 0", cd_mflags[0]); end
        drive(32'd4, 1'b0, 1'b1); tick();
        tests++;
        if (cd_d0 !== 32'd7 || cd_mflags !== 4'b0011) begin
            fails++; $display("FAIL bp_second got %0d/%b exp 7/0011", cd_d0, cd_mflags);
        end
        idle(); tick();
    endtask

    task automatic test_abort();
        N = 32'd2;
        drive(32'd5, 1'b1, 1'b0); tick();
        drive(32'd6, 1'b0, 1'b0); tick();
        tests++;
        if (cd_d0 !== 32'd11 || cd_mflags !== 4'b0101) begin
            fails++; $display("FAIL abort_pre got %0d/%b exp 11/0101", cd_d0, cd_mflags);
        end
        dc_sflags = 2'b11;
        drive(32'd100, 1'b0, 1'b0);
        #1;
        tests++;
        if (cu_sflags !== 2'b11) begin fails++; $display("FAIL abort_sflags got %b exp 11", cu_sflags); end
        tick();
        dc_sflags = 2'b00;
        idle();
        #1;
        tests++;
        if (cd_mflags[0] !== 1'b0 || cd_mflags[3] !== 1'b0) begin
            fails++; $display("FAIL abort_clear got %b exp vld=0 again=0", cd_mflags);
        end
        drive(32'd50, 1'b0, 1'b1); tick();
        tests++;
        if (cd_mflags[0] !== 1'b0) begin fails++; $display("FAIL abort_idle vld got %b exp 0", cd_mflags[0]); end
        drive(32'd1, 1'b1, 1'b0); tick();
        drive(32'd1, 1'b0, 1'b1); tick();
        tests++;
        if (cd_d0 !== 32'd2 || cd_mflags !== 4'b0111) begin
            fails++; $display("FAIL abort_after got %0d/%b exp 2/0111", cd_d0, cd_mflags);
        end
        idle(); tick();
    endtask

    task automatic test_mid_reset();
        N = 32'd3;
        for (int i = 0; i < 3; i++) begin
            drive(32'd4, i == 0, 1'b0); tick();
        end
        tests++;
        if (cd_d0 !== 32'd12 || cd_mflags !== 4'b0101) begin
            fails++; $display("FAIL rst_pre got %0d/%b exp 12/0101", cd_d0, cd_mflags);
        end
        dc_sflags = 2'b01;
        drive(32'd4, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (cd_d0 !== 32'd0 || cd_mflags !== 4'b0000 || cu_sflags !== 2'b00) begin
            fails++; $display("FAIL rst_mid got %0d/%b/%b exp 0/0000/00", cd_d0, cd_mflags, cu_sflags);
        end
        tick();
        rst = 1'b0; dc_sflags = 2'b00; idle();
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] exp1;
`ifdef ACC_GRP_SAT_EN
        exp1 = 32'hFFFF_FFFF;
`else
        exp1 = 32'h0000_0010;
`endif
        N = 32'd2;
        drive(32'hFFFF_FFF0, 1'b1, 1'b0); tick();
        drive(32'h0000_0020, 1'b0, 1'b0); tick();
        tests++;
        if (cd_d0 !== exp1 || cd_mflags !== 4'b0101) begin
            fails++; $display("FAIL wrap_sum got %0h/%b exp %0h/0101", cd_d0, cd_mflags, exp1);
        end
        drive(32'd3, 1'b0, 1'b0); tick();
        drive(32'd4, 1'b0, 1'b1); tick();
        tests++;
        if (cd_d0 !== 32'd7 || cd_mflags !== 4'b0011) begin
            fails++; $display("FAIL wrap_next got %0d/%b exp 7/0011", cd_d0, cd_mflags);
        end
        idle(); tick();
    endtask

    task automatic test_restart();
        N = 32'd3;
        drive(32'd9, 1'b1, 1'b0); tick();
        drive(32'd9, 1'b0, 1'b0); tick();
        tests++;
        if (cd_mflags[0] !== 1'b0) begin fails++; $display("FAIL restart_partial vld got %b exp 0", cd_mflags[0]); end
        drive(32'd1, 1'b1, 1'b0); tick();
        drive(32'd2, 1'b0, 1'b0); tick();
        drive(32'd3, 1'b0, 1'b0); tick();
        tests++;
        if (cd_d0 !== 32'd6 || cd_mflags !== 4'b0101) begin
            fails++; $display("FAIL restart_sum got %0d/%b exp 6/0101", cd_d0, cd_mflags);
        end
        drive(32'd1, 1'b0, 1'b1); tick();
        tests++;
        if (cd_d0 !== 32'd1 || cd_mflags !== 4'b0011) begin
            fails++; $display("FAIL restart_end got %0d/%b exp 1/0011", cd_d0, cd_mflags);
        end
        drive(32'd5, 1'b0, 1'b0); tick();
        drive(32'd6, 1'b0, 1'b0); tick();
        tests++;
        if (cd_mflags[0] !== 1'b0 || cu_sflags !== 2'b00) begin
            fails++; $display("FAIL stray_idle got fl=%b sf=%b exp vld=0 sf=00", cd_mflags, cu_sflags);
        end
        idle(); tick();
    endtask

    task automatic test_back_to_back();
        N = 32'd1;
        drive(32'd1, 1'b1, 1'b0); tick();
        tests++;
        if (cd_d0 !== 32'd1 || cd_mflags !== 4'b0101) begin
            fails++; $display("FAIL b2b_0 got %0d/%b exp 1/0101", cd_d0, cd_mflags);
        end
        drive(32'd2, 1'b0, 1'b0); tick();
        tests++;
        if (cd_d0 !== 32'd2 || cd_mflags !== 4'b0001) begin
            fails++; $display("FAIL b2b_1 got %0d/%b exp 2/0001", cd_d0, cd_mflags);
        end
        drive(32'd3, 1'b0, 1'b1); tick();
        tests++;
        if (cd_d0 !== 32'd3 || cd_mflags !== 4'b0011) begin
            fails++; $display("FAIL b2b_2 got %0d/%b exp 3/0011", cd_d0, cd_mflags);
        end
        idle(); tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_backpressure();
        test_abort();
        test_mid_reset();
        test_wrap();
        test_restart();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
